hazard_unit: RTL and testbench



---
 rtl/hazard_unit.sv | 100 ++++++++++
 tb/tb_hazard_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush/forward controller with data-memory wait watchdog.
// Optional HAZARD_PERF_EN builds the stall-cycle and branch-flush performance counters.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic        d_uses_rs,
  input  logic        d_uses_rt,
  input  logic [4:0]  e_rs,
  input  logic [4:0]  e_rt,
  input  logic [4:0]  e_rf_wa,
  input  logic [4:0]  m_rf_wa,
  input  logic [4:0]  w_rf_wa,
  input  logic        e_rf_we,
  input  logic        m_rf_we,
  input  logic        w_rf_we,
  input  logic        e_is_load,
  input  logic        m_branch_taken,
  input  logic        m_dmem_access,
  input  logic        dmem_ready,
  output logic        f_stall,
  output logic        d_stall,
  output logic        e_stall,
  output logic        m_stall,
  output logic        d_flush,
  output logic        e_flush,
  output logic        m_flush,
  output logic        w_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_timeout,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes
);
  typedef enum logic {RUN, MEM_WAIT} state_e;
  state_e      st_q, st_d;
  logic        rst_q;
  logic [15:0] wdog_q, wdog_d;
  logic [16:0] wdog_inc;
  logic        tmo_q, tmo_d;
  logic        mem_wait, br, lu;
  // rst_q forces every output quiet for the cycle after reset is sampled
  assign mem_wait = !rst_q && m_dmem_access && !dmem_ready;
  assign br = !rst_q && !mem_wait && m_branch_taken;
  assign lu = !rst_q && !mem_wait && !m_branch_taken && e_is_load && e_rf_we && e_rf_wa != 5'd0 &&
              ((d_uses_rs && d_rs == e_rf_wa) || (d_uses_rt && d_rt == e_rf_wa));
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    return (m_rf_we && m_rf_wa != 5'd0 && m_rf_wa == rs) ? 2'b01 :
           (w_rf_we && w_rf_wa != 5'd0 && w_rf_wa == rs) ? 2'b10 : 2'b00;
  endfunction
  assign f_stall = mem_wait | lu;
  assign d_stall = mem_wait | lu;
  assign e_stall = mem_wait;
  assign m_stall = mem_wait;
  assign d_flush = br;
  assign e_flush = br | lu;
  assign m_flush = br;
  assign w_flush = mem_wait;
  assign fwd_a = rst_q ? 2'b00 : fwd_sel(e_rs);
  assign fwd_b = rst_q ? 2'b00 : fwd_sel(e_rt);
  assign mem_timeout = tmo_q;
  assign wdog_inc = {1'b0, st_q == MEM_WAIT ? wdog_q : 16'd0} + 17'd1;
  always_comb begin
    st_d = mem_wait ? MEM_WAIT : RUN;
    wdog_d = mem_wait ? (wdog_inc[16] ? 16'hFFFF : wdog_inc[15:0]) : 16'd0;
    tmo_d = tmo_q | (mem_wait && wdog_inc >= 17'(MEM_TIMEOUT));
  end
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      st_q <= RUN;
      wdog_q <= 16'd0;
      tmo_q <= 1'b0;
    end else begin
      st_q <= st_d;
      wdog_q <= wdog_d;
      tmo_q <= tmo_d;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] pstall_q, pflush_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pstall_q <= 32'd0;
      pflush_q <= 32'd0;
    end else begin
      pstall_q <= pstall_q + {31'd0, f_stall | d_stall | e_stall | m_stall};
      pflush_q <= pflush_q + {31'd0, br};
    end
  end
  assign perf_stall_cycles = pstall_q;
  assign perf_flushes = pflush_q;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_flushes = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: randomized scoreboard bench for hazard_unit against a rule-level model.
module tb_hazard_unit;
  localparam int T = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [4:0] d_rs, d_rt, e_rs, e_rt, e_rf_wa, m_rf_wa, w_rf_wa;
  logic d_uses_rs, d_uses_rt, e_rf_we, m_rf_we, w_rf_we;
  logic e_is_load, m_branch_taken, m_dmem_access, dmem_ready;
  logic f_stall, d_stall, e_stall, m_stall, d_flush, e_flush, m_flush, w_flush;
  logic [1:0] fwd_a, fwd_b;
  logic mem_timeout;
  logic [31:0] perf_stall_cycles, perf_flushes;

  hazard_unit #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .d_rs(d_rs), .d_rt(d_rt), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
    .e_rs(e_rs), .e_rt(e_rt), .e_rf_wa(e_rf_wa), .m_rf_wa(m_rf_wa), .w_rf_wa(w_rf_wa),
    .e_rf_we(e_rf_we), .m_rf_we(m_rf_we), .w_rf_we(w_rf_we), .e_is_load(e_is_load),
    .m_branch_taken(m_branch_taken), .m_dmem_access(m_dmem_access), .dmem_ready(dmem_ready),
    .f_stall(f_stall), .d_stall(d_stall), .e_stall(e_stall), .m_stall(m_stall),
    .d_flush(d_flush), .e_flush(e_flush), .m_flush(m_flush), .w_flush(w_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
    .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
  );

  typedef struct {
    logic [11:0] ctl;
    logic        tmo;
    logic [31:0] ps;
    logic [31:0] pf;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  bit prev_rst = 0;
  int wait_cnt = 0;
  bit tmo = 0;
  logic [31:0] ps = 0;
  logic [31:0] pf = 0;

  function automatic logic [1:0] fwd(input logic [4:0] r);
    if (r == 0) return 2'b00;
    if (m_rf_we && m_rf_wa == r) return 2'b01;
    if (w_rf_we && w_rf_wa == r) return 2'b10;
    return 2'b00;
  endfunction

  // {f,d,e,m stall, d,e,m,w flush, fwd_a, fwd_b}
  function automatic logic [11:0] calc();
    logic [11:0] c;
    logic lu;
    c = '0;
    if (prev_rst) return c;
    lu = e_is_load && e_rf_we && e_rf_wa != 0 &&
         ((d_uses_rs && d_rs == e_rf_wa) || (d_uses_rt && d_rt == e_rf_wa));
    if (m_dmem_access && !dmem_ready) begin
      c[11:8] = 4'hF;
      c[4] = 1'b1;
    end else if (m_branch_taken) c[7:5] = 3'b111;
    else if (lu) begin
      c[11:10] = 2'b11;
      c[6] = 1'b1;
    end
    c[3:2] = fwd(e_rs);
    c[1:0] = fwd(e_rt);
    return c;
  endfunction

  task automatic model_edge();
    logic [11:0] c;
    c = calc();
    if (rst) begin
      prev_rst = 1;
      wait_cnt = 0;
      tmo = 0;
      ps = 0;
      pf = 0;
    end else begin
      prev_rst = 0;
      if (c[4]) begin
        wait_cnt++;
        if (wait_cnt >= T) tmo = 1;
      end else wait_cnt = 0;
`ifdef HAZARD_PERF_EN
      if (|c[11:8]) ps = ps + 1;
      if (c[7]) pf = pf + 1;
`endif
    end
  endtask

  task automatic step(input int mode);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rst = (mode == 2);
    d_rs = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
    e_rs = 5'($urandom_range(0, 3)); e_rt = 5'($urandom_range(0, 3));
    e_rf_wa = 5'($urandom_range(0, 3)); m_rf_wa = 5'($urandom_range(0, 3));
    w_rf_wa = 5'($urandom_range(0, 3));
    d_uses_rs = 1'($urandom); d_uses_rt = 1'($urandom);
    e_rf_we = 1'($urandom); m_rf_we = 1'($urandom); w_rf_we = 1'($urandom);
    e_is_load = 1'($urandom);
    m_branch_taken = ($urandom_range(0, 5) == 0);
    m_dmem_access = ($urandom_range(0, 3) == 0) || mode == 1;
    dmem_ready = 1'($urandom) && mode != 1;
    e.ctl = calc();
    e.tmo = tmo;
    e.ps = ps;
    e.pf = pf;
    q.push_back(e);
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ctl", 32'({f_stall, d_stall, e_stall, m_stall, d_flush, e_flush, m_flush, w_flush, fwd_a, fwd_b}), 32'(e.ctl));
      chk("mem_timeout", 32'(mem_timeout), 32'(e.tmo));
      chk("perf_stall_cycles", perf_stall_cycles, e.ps);
      chk("perf_flushes", perf_flushes, e.pf);
    end
  end

  initial begin
    rst = 1;
    {d_rs, d_rt, e_rs, e_rt, e_rf_wa, m_rf_wa, w_rf_wa} = '0;
    {d_uses_rs, d_uses_rt, e_rf_we, m_rf_we, w_rf_we} = '0;
    {e_is_load, m_branch_taken, m_dmem_access, dmem_ready} = '0;
    repeat (3) step(2);
    repeat (150) step(0);
    repeat (3) step(1);
    repeat (20) step(0);
    repeat (10) step(1);
    repeat (5) step(0);
    repeat (6) step(1);
    step(2);
    repeat (200) step(0);
    repeat (12) step(1);
    repeat (300) step(0);
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
